// File: rtl/rps_match_controller.sv
// Best-of-N rock-paper-scissors match sequencer: arbitrates button/PMOD choices,
// draws the computer's choice, scores each round and drives the result LEDs.
module rps_match_controller #(
  parameter int HOLD_CYCLES   = 12_000_000,
  parameter int FLASH_CYCLES  = 1_500_000,
  parameter int WINS_TO_MATCH = 3
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic [2:0] btn_req,
  input  logic [2:0] pmod_req,
  output logic [1:0] person_choice,
  output logic [1:0] computer_choice,
  output logic       src_sel,
  output logic [2:0] result,
  output logic       result_valid,
  output logic [3:0] person_score,
  output logic [3:0] computer_score,
  output logic       match_over,
  output logic [2:0] leds
);

  localparam int HW = $clog2(2 * HOLD_CYCLES + 1);
  localparam int FW = $clog2(FLASH_CYCLES + 1);
  localparam logic [3:0] WINS = 4'(WINS_TO_MATCH);

  typedef enum logic [2:0] {IDLE, EVAL, SHOW, RELEASE, MATCH_END} state_t;

  state_t        state, state_nx;
  logic [1:0]    mod3, mod3_nx;
  logic          phase, phase_nx, phase_step;
  logic [FW-1:0] flash_cnt, flash_nx, flash_step;
  logic [HW-1:0] hold_cnt, hold_nx;
  logic          rr_ptr, rr_nx;
  logic [1:0]    person_nx, computer_nx;
  logic          src_nx;
  logic [2:0]    result_nx, outcome, leds_nx, winner_code;
  logic          valid_nx;
  logic [3:0]    pscore_nx, cscore_nx;
  logic          btn_ok, pmod_ok, take_pmod;

  function automatic logic one_hot3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

  function automatic logic [1:0] encode(input logic [2:0] v);
    case (v)
      3'b001:  return 2'd1;
      3'b010:  return 2'd2;
      3'b100:  return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [2:0] judge(input logic [1:0] p, input logic [1:0] c);
    if (p == c) return 3'b100;
    if ((p == 2'd1 && c == 2'd3) || (p == 2'd2 && c == 2'd1) || (p == 2'd3 && c == 2'd2))
      return 3'b001;
    return 3'b010;
  endfunction

  assign btn_ok      = one_hot3(btn_req);
  assign pmod_ok     = one_hot3(pmod_req);
  assign outcome     = judge(person_choice, computer_choice);
  assign winner_code = (person_score == WINS) ? 3'b001 : 3'b010;
  assign flash_step  = (flash_cnt == FW'(FLASH_CYCLES - 1)) ? '0 : flash_cnt + 1'b1;
  assign phase_step  = (flash_cnt == FW'(FLASH_CYCLES - 1)) ? ~phase : phase;
  assign match_over  = (state == MATCH_END);

  always_comb begin
    state_nx    = state;
    mod3_nx     = (mod3 == 2'd2) ? 2'd0 : mod3 + 2'd1;
    phase_nx    = phase;
    flash_nx    = flash_cnt;
    hold_nx     = hold_cnt;
    rr_nx       = rr_ptr;
    person_nx   = person_choice;
    computer_nx = computer_choice;
    src_nx      = src_sel;
    result_nx   = result;
    valid_nx    = 1'b0;
    pscore_nx   = person_score;
    cscore_nx   = computer_score;
    leds_nx     = leds;
    take_pmod   = 1'b0;

    case (state)
      IDLE: begin
        flash_nx = flash_step;
        phase_nx = phase_step;
        leds_nx  = phase ? 3'b100 : 3'b011;
        if (btn_ok || pmod_ok) begin
          // Contested accepts alternate between sources; uncontested ones leave the pointer alone.
          take_pmod = pmod_ok && (!btn_ok || rr_ptr);
          if (btn_ok && pmod_ok) rr_nx = ~rr_ptr;
          person_nx   = encode(take_pmod ? pmod_req : btn_req);
          computer_nx = mod3 + 2'd1;
          src_nx      = take_pmod;
          state_nx    = EVAL;
        end
      end
      EVAL: begin
        result_nx = outcome;
        if (outcome[0]) pscore_nx = person_score + 4'd1;
        if (outcome[1]) cscore_nx = computer_score + 4'd1;
        valid_nx  = 1'b1;
        leds_nx   = outcome;
        hold_nx   = '0;
        state_nx  = SHOW;
      end
      SHOW: begin
        hold_nx = hold_cnt + 1'b1;
        if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
          hold_nx  = '0;
          leds_nx  = 3'b000;
          state_nx = RELEASE;
        end
      end
      RELEASE: begin
        // A button still held from the last round must be let go before play resumes.
        if (btn_req == 3'b000 && pmod_req == 3'b000) begin
          hold_nx  = '0;
          flash_nx = '0;
          phase_nx = 1'b0;
          if (person_score == WINS || computer_score == WINS) begin
            leds_nx  = winner_code;
            state_nx = MATCH_END;
          end else begin
            leds_nx  = 3'b000;
            state_nx = IDLE;
          end
        end
      end
      MATCH_END: begin
        hold_nx  = hold_cnt + 1'b1;
        flash_nx = flash_step;
        phase_nx = phase_step;
        leds_nx  = phase_step ? 3'b000 : winner_code;
        if (hold_cnt == HW'(2 * HOLD_CYCLES - 1)) begin
          hold_nx     = '0;
          flash_nx    = '0;
          phase_nx    = 1'b0;
          leds_nx     = 3'b000;
          pscore_nx   = 4'd0;
          cscore_nx   = 4'd0;
          person_nx   = 2'd0;
          computer_nx = 2'd0;
          result_nx   = 3'b000;
          state_nx    = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state           <= IDLE;
      mod3            <= 2'd0;
      phase           <= 1'b0;
      flash_cnt       <= '0;
      hold_cnt        <= '0;
      rr_ptr          <= 1'b0;
      person_choice   <= 2'd0;
      computer_choice <= 2'd0;
      src_sel         <= 1'b0;
      result          <= 3'b000;
      result_valid    <= 1'b0;
      person_score    <= 4'd0;
      computer_score  <= 4'd0;
      leds            <= 3'b000;
    end else begin
      state           <= state_nx;
      mod3            <= mod3_nx;
      phase           <= phase_nx;
      flash_cnt       <= flash_nx;
      hold_cnt        <= hold_nx;
      rr_ptr          <= rr_nx;
      person_choice   <= person_nx;
      computer_choice <= computer_nx;
      src_sel         <= src_nx;
      result          <= result_nx;
      result_valid    <= valid_nx;
      person_score    <= pscore_nx;
      computer_score  <= cscore_nx;
      leds            <= leds_nx;
    end
  end

endmodule

// File: tb/tb_rps_match_controller.sv
// Self-checking bench for rps_match_controller: directed match scenarios followed by
// random play, every cycle compared against a behavioural model of the game.
module tb_rps_match_controller;

  localparam int HOLD  = 8;
  localparam int FLASH = 2;
  localparam int WINS  = 3;

  logic       clk = 1'b0;
  logic       resetn;
  logic [2:0] btn_req, pmod_req;
  logic [1:0] person_choice, computer_choice;
  logic       src_sel, result_valid, match_over;
  logic [2:0] result, leds;
  logic [3:0] person_score, computer_score;

  always #5 clk = ~clk;

  rps_match_controller #(
    .HOLD_CYCLES(HOLD), .FLASH_CYCLES(FLASH), .WINS_TO_MATCH(WINS)
  ) dut (
    .CLK(clk), .RESETN(resetn), .btn_req(btn_req), .pmod_req(pmod_req),
    .person_choice(person_choice), .computer_choice(computer_choice), .src_sel(src_sel),
    .result(result), .result_valid(result_valid), .person_score(person_score),
    .computer_score(computer_score), .match_over(match_over), .leds(leds)
  );

  // Game model: where the match is, how long it has been there, and the expected outputs.
  typedef enum int {M_IDLE, M_EVAL, M_SHOW, M_RELEASE, M_END} mode_t;
  mode_t mode = M_IDLE;
  int    age = 0, tick = 0;
  bit    prefer_pmod = 0;
  int    e_pc = 0, e_cc = 0, e_src = 0, e_res = 0, e_rv = 0;
  int    e_ps = 0, e_cs = 0, e_mo = 0, e_leds = 0;

  int checks = 0, errors = 0;

  task automatic modelEdge(input logic [2:0] b, input logic [2:0] p, input logic r);
    int cnt, d, pick;
    logic [2:0] chosen;
    pick = 0;
    if (!r) begin
      mode = M_IDLE; age = 0; tick = 0; prefer_pmod = 0;
      e_pc = 0; e_cc = 0; e_src = 0; e_res = 0; e_rv = 0;
      e_ps = 0; e_cs = 0; e_mo = 0; e_leds = 0;
      return;
    end
    cnt  = tick % 3;
    tick = tick + 1;
    e_rv = 0;
    case (mode)
      M_IDLE: begin
        e_leds = ((age / FLASH) % 2) != 0 ? 3'b100 : 3'b011;
        age++;
        if ($countones(b) == 1 || $countones(p) == 1) begin
          if ($countones(b) == 1 && $countones(p) == 1) begin
            chosen = prefer_pmod ? p : b;
            e_src = prefer_pmod ? 1 : 0;
            prefer_pmod = !prefer_pmod;
          end else if ($countones(b) == 1) begin
            chosen = b; e_src = 0;
          end else begin
            chosen = p; e_src = 1;
          end
          for (int i = 0; i < 3; i++) if (chosen[i]) pick = i + 1;
          e_pc = pick;
          e_cc = cnt + 1;
          mode = M_EVAL;
        end
      end
      M_EVAL: begin
        d = (e_pc - e_cc + 3) % 3;
        e_res = (d == 0) ? 4 : (d == 1) ? 1 : 2;
        if (d == 1) e_ps++;
        if (d == 2) e_cs++;
        e_rv = 1; e_leds = e_res; mode = M_SHOW; age = 0;
      end
      M_SHOW: begin
        age++;
        if (age == HOLD) begin mode = M_RELEASE; e_leds = 0; end
      end
      M_RELEASE: begin
        if (b == 0 && p == 0) begin
          age = 0;
          if (e_ps == WINS || e_cs == WINS) begin
            mode = M_END; e_leds = (e_ps == WINS) ? 1 : 2;
          end else begin
            mode = M_IDLE; e_leds = 0;
          end
        end
      end
      M_END: begin
        age++;
        if (age == 2 * HOLD) begin
          mode = M_IDLE; age = 0; e_leds = 0;
          e_ps = 0; e_cs = 0; e_pc = 0; e_cc = 0; e_res = 0;
        end else begin
          e_leds = ((age / FLASH) % 2) != 0 ? 0 : ((e_ps == WINS) ? 1 : 2);
        end
      end
      default: mode = M_IDLE;
    endcase
    e_mo = (mode == M_END) ? 1 : 0;
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkValue("person_choice", 32'(person_choice), e_pc);
    checkValue("computer_choice", 32'(computer_choice), e_cc);
    checkValue("src_sel", 32'(src_sel), e_src);
    checkValue("result", 32'(result), e_res);
    checkValue("result_valid", 32'(result_valid), e_rv);
    checkValue("person_score", 32'(person_score), e_ps);
    checkValue("computer_score", 32'(computer_score), e_cs);
    checkValue("match_over", 32'(match_over), e_mo);
    checkValue("leds", 32'(leds), e_leds);
  endtask

  task automatic applyStimulus(input logic [2:0] b, input logic [2:0] p, input logic r);
    btn_req = b; pmod_req = p; resetn = r;
    @(posedge clk);
    modelEdge(b, p, r);
    @(negedge clk);
    checkOutput();
  endtask

  // Idles until the edge about to be taken samples the free-running counter at want.
  task automatic alignTo(input int want);
    for (int i = 0; i < 3 && (tick % 3) != want; i++) applyStimulus(3'b000, 3'b000, 1'b1);
  endtask

  task automatic playOut();
    repeat (1 + HOLD) applyStimulus(3'b000, 3'b000, 1'b1);
  endtask

  initial begin
    logic [2:0] idle_pat [4];
    int mo_cycles;
    idle_pat = '{3'b011, 3'b011, 3'b100, 3'b100};
    btn_req = 3'b000; pmod_req = 3'b000; resetn = 1'b0;
    @(negedge clk);

    repeat (3) applyStimulus(3'b000, 3'b000, 1'b0);
    checkValue("reset_leds", 32'(leds), 0);
    checkValue("reset_score", 32'(person_score), 0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(3'b000, 3'b000, 1'b1);
      checkValue("idle_flash", 32'(leds), 32'(idle_pat[i % 4]));
    end

    // Round 1: rock against scissors, button held well into RELEASE.
    alignTo(2);
    applyStimulus(3'b001, 3'b000, 1'b1);
    checkValue("r1_person", 32'(person_choice), 1);
    checkValue("r1_computer", 32'(computer_choice), 3);
    checkValue("r1_src", 32'(src_sel), 0);
    applyStimulus(3'b001, 3'b000, 1'b1);
    checkValue("r1_result", 32'(result), 1);
    checkValue("r1_valid", 32'(result_valid), 1);
    checkValue("r1_score", 32'(person_score), 1);
    for (int i = 0; i < HOLD - 1; i++) begin
      applyStimulus(3'b001, 3'b000, 1'b1);
      checkValue("r1_show_leds", 32'(leds), 1);
    end
    repeat (5) applyStimulus(3'b001, 3'b000, 1'b1);
    checkValue("r1_held_no_round", 32'(result_valid), 0);
    applyStimulus(3'b000, 3'b000, 1'b1);

    // Round 2/3: contested sources alternate, buttons first.
    alignTo(0);
    applyStimulus(3'b010, 3'b100, 1'b1);
    checkValue("r2_src", 32'(src_sel), 0);
    checkValue("r2_person", 32'(person_choice), 2);
    playOut();
    applyStimulus(3'b000, 3'b000, 1'b1);
    alignTo(2);
    applyStimulus(3'b010, 3'b100, 1'b1);
    checkValue("r3_src", 32'(src_sel), 1);
    checkValue("r3_person", 32'(person_choice), 3);
    playOut();
    checkValue("r3_tie", 32'(result), 4);
    applyStimulus(3'b000, 3'b000, 1'b1);

    // Multi-bit button request alone is ignored; alongside a valid PMOD the PMOD wins.
    repeat (4) applyStimulus(3'b011, 3'b000, 1'b1);
    checkValue("multibit_ignored", 32'(person_choice), 3);
    alignTo(2);
    applyStimulus(3'b011, 3'b001, 1'b1);
    checkValue("r4_src", 32'(src_sel), 1);
    checkValue("r4_person", 32'(person_choice), 1);
    playOut();
    checkValue("r4_score", 32'(person_score), 3);

    mo_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(3'b000, 3'b000, 1'b1);
      if (match_over) mo_cycles++;
    end
    checkValue("match_over_len", 32'(mo_cycles), 16);
    checkValue("match_cleared", 32'(person_score), 0);

    // Reset in the middle of SHOW.
    applyStimulus(3'b100, 3'b000, 1'b1);
    repeat (4) applyStimulus(3'b000, 3'b000, 1'b1);
    applyStimulus(3'b000, 3'b000, 1'b0);
    checkValue("midshow_rst_result", 32'(result), 0);
    checkValue("midshow_rst_leds", 32'(leds), 0);
    checkValue("midshow_rst_choice", 32'(person_choice), 0);
    checkValue("midshow_rst_score", 32'(person_score) + 32'(computer_score), 0);

    // Random play against the model.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000,
                    ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000,
                    ($urandom_range(0, 299) != 0));
    end

    $display("[TB] stimulus complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
